// File: rtl/or1200_wbmux_pkg.sv
// Shared definitions for the OR1200 write-back mux with coprocessor handshake:
// source index map, handshake FSM encoding and a small select helper.
package or1200_wbmux_pkg;

   // Write-back source indices
   localparam int unsigned WBSRC_ALU    = 0;
   localparam int unsigned WBSRC_LSU    = 1;
   localparam int unsigned WBSRC_SPRS   = 2;
   localparam int unsigned WBSRC_LR     = 3;
   localparam int unsigned WBSRC_FPU    = 4;
   localparam int unsigned WBSRC_KECCAK = 5;

   // Number of sources defined above; default for NSRC
   localparam int unsigned WBSRC_COUNT  = WBSRC_KECCAK + 1;

   // Coprocessor handshake FSM states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StReady = 2'd2
   } cop_state_e;

   // True when a select value addresses an existing source
   function automatic logic sel_in_range(input int unsigned sel, input int unsigned nsrc);
      return sel < nsrc;
   endfunction

endpackage

// File: rtl/or1200_wbmux_cophs.sv
// Coprocessor valid/ack handshake: waits for a multi-cycle result, buffers it,
// and aborts with a zero result after TIMEOUT cycles without cop_valid.
module or1200_wbmux_cophs
   import or1200_wbmux_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wb_freeze,
   input  logic             i_cop_req,
   input  logic             i_cop_valid,
   input  logic [WIDTH-1:0] i_cop_data,
   output logic             o_wb_stall,
   output logic             o_cop_ack,
   output logic             o_cop_timeout,
   output logic             o_use_buf,
   output logic [WIDTH-1:0] o_cop_buf
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   cop_state_e       r_state;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_cop_buf;
   logic             w_cnt_done;

   assign w_cnt_done = (r_cnt == CntMax);

   // State, wait counter and result buffer; counting ignores wb_freeze
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_cop_buf <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               // Fast path (cop_valid already high) never leaves IDLE
               if (i_cop_req && !i_wb_freeze && !i_cop_valid) begin
                  r_state <= StWait;
                  r_cnt   <= '0;
               end
            end
            StWait: begin
               if (i_cop_valid) begin
                  r_cop_buf <= i_cop_data;
                  r_state   <= StReady;
               end else if (w_cnt_done) begin
                  r_cop_buf <= '0;
                  r_state   <= StReady;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StReady: begin
               // The mux register captures cop_buf on this same edge
               if (!i_wb_freeze) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Handshake outputs decoded from the current state and inputs
   always_comb begin
      o_wb_stall    = (r_state == StWait);
      o_use_buf     = (r_state == StReady);
      o_cop_ack     = 1'b0;
      o_cop_timeout = 1'b0;
      unique case (r_state)
         StIdle: o_cop_ack = i_cop_req && !i_wb_freeze && i_cop_valid;
         StWait: begin
            o_cop_ack     = i_cop_valid;
            o_cop_timeout = !i_cop_valid && w_cnt_done;
         end
         default: ;
      endcase
   end

   assign o_cop_buf = r_cop_buf;

endmodule

// File: rtl/or1200_wbmux_cop.sv
// OR1200 write-back mux: selects one of NSRC result sources for the register
// file, registers it for forwarding, and stalls WB for a multi-cycle coprocessor.
module or1200_wbmux_cop
   import or1200_wbmux_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NSRC    = WBSRC_COUNT,
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned COP_SRC = WBSRC_KECCAK,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wb_freeze,
   input  logic [SEL_W:0]        i_rfwb_op,
   input  logic [NSRC*WIDTH-1:0] i_muxin,
   input  logic                  i_cop_valid,
   output logic                  o_cop_ack,
   output logic                  o_wb_stall,
   output logic                  o_cop_timeout,
   output logic                  o_sel_err,
   output logic [WIDTH-1:0]      o_muxout,
   output logic [WIDTH-1:0]      o_muxreg,
   output logic                  o_muxreg_valid
);

   logic [SEL_W-1:0] w_sel;
   logic             w_we;
   logic             w_sel_ok;
   logic             w_cop_sel;
   logic             w_cop_req;
   logic [WIDTH-1:0] w_cop_data;
   logic [WIDTH-1:0] w_src_data;
   logic [WIDTH-1:0] w_muxout;
   logic             w_wb_stall;
   logic             w_use_buf;
   logic [WIDTH-1:0] w_cop_buf;
   logic [WIDTH-1:0] r_muxreg;
   logic             r_muxreg_valid;

   assign w_sel      = i_rfwb_op[SEL_W:1];
   assign w_we       = i_rfwb_op[0];
   assign w_sel_ok   = sel_in_range(32'(w_sel), NSRC);
   assign w_cop_sel  = (32'(w_sel) == COP_SRC);
   assign w_cop_req  = w_we && w_cop_sel;
   assign w_cop_data = i_muxin[COP_SRC*WIDTH +: WIDTH];

   or1200_wbmux_cophs #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) u_cophs (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_wb_freeze   (i_wb_freeze),
      .i_cop_req     (w_cop_req),
      .i_cop_valid   (i_cop_valid),
      .i_cop_data    (w_cop_data),
      .o_wb_stall    (w_wb_stall),
      .o_cop_ack     (o_cop_ack),
      .o_cop_timeout (o_cop_timeout),
      .o_use_buf     (w_use_buf),
      .o_cop_buf     (w_cop_buf)
   );

   // N-way source select; out-of-range selects yield zero
   always_comb begin
      w_src_data = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (int'(w_sel) == i) begin
            w_src_data = i_muxin[i*WIDTH +: WIDTH];
         end
      end
   end

   // Coprocessor select reads the live input, the buffer, or zero while waiting
   always_comb begin
      w_muxout = w_src_data;
      if (w_cop_sel) begin
         if (w_use_buf) begin
            w_muxout = w_cop_buf;
         end else if (w_wb_stall) begin
            w_muxout = '0;
         end else begin
            w_muxout = w_cop_data;
         end
      end
   end

   // Forwarding register; holds across freeze and coprocessor stall
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_muxreg       <= '0;
         r_muxreg_valid <= 1'b0;
      end else if (!i_wb_freeze && !w_wb_stall) begin
         r_muxreg       <= w_muxout;
         r_muxreg_valid <= w_we && w_sel_ok;
      end
   end

   assign o_sel_err      = w_we && !w_sel_ok;
   assign o_muxout       = w_muxout;
   assign o_wb_stall     = w_wb_stall;
   assign o_muxreg       = r_muxreg;
   assign o_muxreg_valid = r_muxreg_valid;

endmodule

// File: tb/tb_or1200_wbmux_cop.sv
// Self-checking bench for or1200_wbmux_cop: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_or1200_wbmux_cop;

   localparam int W   = 32;
   localparam int N   = 6;
   localparam int SW  = 3;
   localparam int COP = 5;
   localparam int TO  = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             frz;
   logic             cv;
   logic [SW:0]      op;
   logic [N*W-1:0]   muxin;
   logic             o_ack, o_stall, o_tmo, o_serr, o_mregv;
   logic [W-1:0]     o_mout, o_mreg;

   int checks   = 0;
   int failures = 0;
   int n_ack    = 0;
   int n_tmo    = 0;
   int n_stall  = 0;

   // Model state: mode 0 = no pending result, 1 = waiting, 2 = result held
   bit           m_known = 1'b0;
   int           m_mode;
   int           m_waited;
   logic [W-1:0] m_buf;
   logic [W-1:0] m_reg;
   logic         m_regv;

   or1200_wbmux_cop #(
      .WIDTH   (W),
      .NSRC    (N),
      .SEL_W   (SW),
      .COP_SRC (COP),
      .TIMEOUT (TO)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wb_freeze    (frz),
      .i_rfwb_op      (op),
      .i_muxin        (muxin),
      .i_cop_valid    (cv),
      .o_cop_ack      (o_ack),
      .o_wb_stall     (o_stall),
      .o_cop_timeout  (o_tmo),
      .o_sel_err      (o_serr),
      .o_muxout       (o_mout),
      .o_muxreg       (o_mreg),
      .o_muxreg_valid (o_mregv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] src(input int i);
      return muxin[i*W +: W];
   endfunction

   function automatic int e_sel();
      return int'(op[SW:1]);
   endfunction

   function automatic logic e_req();
      return op[0] && e_sel() == COP;
   endfunction

   function automatic logic [W-1:0] e_muxout();
      if (e_sel() >= N) return '0;
      if (e_sel() != COP) return src(e_sel());
      if (m_mode == 2) return m_buf;
      if (m_mode == 1) return '0;
      return src(COP);
   endfunction

   function automatic logic e_ack();
      return (m_mode == 0 && e_req() && !frz && cv) || (m_mode == 1 && cv);
   endfunction

   function automatic logic e_tmo();
      return m_mode == 1 && !cv && m_waited == TO - 1;
   endfunction

   // Reference model advance on each rising edge
   always @(posedge clk) begin
      logic [W-1:0] mo;
      logic         stall;
      if (rst) begin
         m_known  = 1'b1;
         m_mode   = 0;
         m_waited = 0;
         m_buf    = '0;
         m_reg    = '0;
         m_regv   = 1'b0;
      end else if (m_known) begin
         mo    = e_muxout();
         stall = (m_mode == 1);
         if (!frz && !stall) begin
            m_reg  = mo;
            m_regv = op[0] && e_sel() < N;
         end
         case (m_mode)
            0: if (e_req() && !frz && !cv) begin
                  m_mode   = 1;
                  m_waited = 0;
               end
            1: if (cv) begin
                  m_buf  = src(COP);
                  m_mode = 2;
               end else if (m_waited == TO - 1) begin
                  m_buf  = '0;
                  m_mode = 2;
               end else begin
                  m_waited++;
               end
            default: if (!frz) m_mode = 0;
         endcase
      end
   end

   // Compare process: all outputs against the model every cycle
   always @(negedge clk) begin
      if (m_known) begin
         chk("wb_stall", 32'(o_stall), 32'(m_mode == 1));
         chk("cop_ack", 32'(o_ack), 32'(e_ack()));
         chk("cop_timeout", 32'(o_tmo), 32'(e_tmo()));
         chk("sel_err", 32'(o_serr), 32'(op[0] && e_sel() >= N));
         chk("muxout", o_mout, e_muxout());
         chk("muxreg", o_mreg, m_reg);
         chk("muxreg_valid", 32'(o_mregv), 32'(m_regv));
      end
      if (o_ack) n_ack++;
      if (o_tmo) n_tmo++;
      if (o_stall) n_stall++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] sweep_exp [N];
      sweep_exp = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
                    32'h4000_0000, 32'h5000_0000, 32'h6000_0000};
      rst = 1'b1; frz = 1'b0; cv = 1'b0; op = '0;
      for (int i = 0; i < N; i++) muxin[i*W +: W] = sweep_exp[i];
      tick();
      tick();
      rst = 1'b0;
      chk("reset_muxreg", o_mreg, 32'h0);
      chk("reset_valid", 32'(o_mregv), 32'h0);
      chk("reset_stall", 32'(o_stall), 32'h0);

      // Source sweep, KECCAK via fast path
      for (int i = 0; i < N; i++) begin
         op = {3'(i), 1'b1};
         cv = (i == COP);
         tick();
         cv = 1'b0;
         chk("sweep_muxreg", o_mreg, sweep_exp[i]);
         chk("sweep_valid", 32'(o_mregv), 32'h1);
      end

      // Write disabled
      op = 4'b1010;
      #1;
      chk("wdis_ack", 32'(o_ack), 32'h0);
      tick();
      chk("wdis_valid", 32'(o_mregv), 32'h0);

      // Slow coprocessor
      op = 4'b1011; cv = 1'b0; n_stall = 0; n_ack = 0;
      repeat (6) tick();
      muxin[COP*W +: W] = 32'hCAFE_F00D;
      cv = 1'b1;
      tick();
      cv = 1'b0;
      tick();
      op = 4'b0000;
      chk("slow_muxreg", o_mreg, 32'hCAFE_F00D);
      chk("slow_valid", 32'(o_mregv), 32'h1);
      chk("slow_stall_cycles", 32'(n_stall), 32'd6);
      chk("slow_ack_pulses", 32'(n_ack), 32'd1);

      // Timeout
      op = 4'b1011; cv = 1'b0; n_tmo = 0;
      repeat (10) tick();
      op = 4'b0000;
      chk("tmo_muxreg", o_mreg, 32'h0);
      chk("tmo_valid", 32'(o_mregv), 32'h1);
      chk("tmo_pulses", 32'(n_tmo), 32'd1);
      chk("tmo_idle_stall", 32'(o_stall), 32'h0);

      // Freeze while result is held
      op = 4'b1011; cv = 1'b0;
      tick();
      muxin[COP*W +: W] = 32'hABCD_1234;
      cv = 1'b1;
      tick();
      cv = 1'b0; frz = 1'b1;
      repeat (3) tick();
      chk("frz_hold", o_mreg, 32'hCAFE_F00D);
      frz = 1'b0;
      tick();
      chk("frz_release", o_mreg, 32'hABCD_1234);
      op = 4'b1111;
      #1;
      chk("selerr_flag", 32'(o_serr), 32'h1);
      tick();
      chk("selerr_valid", 32'(o_mregv), 32'h0);
      chk("selerr_muxreg", o_mreg, 32'h0);

      // Reset mid-WAIT, then a late cop_valid
      op = 4'b1011; cv = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; op = 4'b0000;
      chk("rst_stall", 32'(o_stall), 32'h0);
      chk("rst_muxreg", o_mreg, 32'h0);
      chk("rst_valid", 32'(o_mregv), 32'h0);
      n_ack = 0;
      cv = 1'b1;
      repeat (3) tick();
      cv = 1'b0;
      chk("late_valid_no_ack", 32'(n_ack), 32'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         op  = 4'($urandom_range(0, 15));
         cv  = ($urandom_range(0, 3) == 0);
         frz = ($urandom_range(0, 4) == 0);
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < N; i++) muxin[i*W +: W] = $urandom;
         tick();
      end
      rst = 1'b0; frz = 1'b0; cv = 1'b0; op = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
